// File: rtl/div_mae_monitor_pkg.sv
// Shared definitions for the divider MAE monitor: default widths, FSM states, iteration count.
package div_mae_monitor_pkg;

    localparam int NW_DEF    = 16;
    localparam int DW_DEF    = 8;
    localparam int ACC_W_DEF = 32;
    localparam int CNT_W_DEF = 24;
    localparam int ITER      = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        CALC  = 2'd2,
        ACC   = 2'd3
    } state_t;

endpackage

// File: rtl/div_mae_monitor_restore_seq.sv
// Bit-serial restoring divider: one quotient bit per cycle, MSB first, after a start load.
module div_restore_seq
    import div_mae_monitor_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW:0]   p_init,
    input  logic [DW-1:0] n_lo,
    input  logic [DW-1:0] d,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] q_ex,
    output logic [DW-1:0] rem
);

    localparam int IW = $clog2(DW);

    logic [DW:0]   p;
    logic [DW-1:0] n_lo_r;
    logic [DW-1:0] d_r;
    logic [IW-1:0] idx;
    logic [DW:0]   t;
    logic          ge;

    assign t    = {p[DW-1:0], n_lo_r[idx]};
    assign ge   = (t >= {1'b0, d_r});
    // done flags the final iteration, so results are settled on the following cycle
    assign done = busy && (idx == '0);
    assign rem  = p[DW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p      <= '0;
            n_lo_r <= '0;
            d_r    <= '0;
            idx    <= '0;
            busy   <= 1'b0;
            q_ex   <= '0;
        end else if (start) begin
            p      <= p_init;
            n_lo_r <= n_lo;
            d_r    <= d;
            idx    <= IW'(DW - 1);
            busy   <= 1'b1;
            q_ex   <= '0;
        end else if (busy) begin
            q_ex[idx] <= ge;
            p         <= ge ? (t - {1'b0, d_r}) : t;
            if (idx == '0) begin
                busy <= 1'b0;
            end else begin
                idx <= idx - 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_mae_monitor.sv
// Exact-vs-approximate divider error monitor; remainder comparison enabled by DIV_MAE_REM_CHECK_EN.
module div_mae_monitor
    import div_mae_monitor_pkg::*;
#(
    parameter int NW    = NW_DEF,
    parameter int DW    = DW_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NW-1:0]    n,
    input  logic [DW-1:0]    d,
    input  logic [DW-1:0]    q_apx,
    input  logic [DW-1:0]    r_apx,
    input  logic             clear,
    output logic             res_valid,
    output logic [DW-1:0]    err_abs,
    output logic [ACC_W-1:0] err_sum,
    output logic [DW-1:0]    err_max,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [CNT_W-1:0] rem_mis_cnt
);

    state_t        state, state_next;
    logic [NW-1:0] n_r;
    logic [DW-1:0] d_r;
    logic [DW-1:0] q_apx_r;
    logic          skip_s, start_s;
    logic          seq_busy, seq_done;
    logic [DW-1:0] q_ex, seq_rem, err_new;
    logic [ACC_W:0] sum_ext;

    // quotient would not fit in DW bits (or divide by zero)
    assign skip_s  = (d_r == '0) || (n_r[NW-1:DW] >= d_r);
    assign err_new = (q_apx_r >= q_ex) ? (q_apx_r - q_ex) : (q_ex - q_apx_r);
    assign sum_ext = {1'b0, err_sum} + {{(ACC_W + 1 - DW){1'b0}}, err_new};

    div_restore_seq #(.DW(DW)) u_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s),
        .p_init ({1'b0, n_r[NW-1:DW]}),
        .n_lo   (n_r[DW-1:0]),
        .d      (d_r),
        .busy   (seq_busy),
        .done   (seq_done),
        .q_ex   (q_ex),
        .rem    (seq_rem)
    );

    // next-state and sequencer start
    always_comb begin
        state_next = state;
        start_s    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) state_next = CHECK;
                else          state_next = IDLE;
            end
            CHECK: begin
                if (skip_s) begin
                    state_next = IDLE;
                end else begin
                    start_s    = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (seq_done) state_next = ACC;
                else          state_next = CALC;
            end
            ACC:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // state register, handshake and operand capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            n_r      <= '0;
            d_r      <= '0;
            q_apx_r  <= '0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == IDLE);
            if (in_valid && in_ready) begin
                n_r     <= n;
                d_r     <= d;
                q_apx_r <= q_apx;
            end
        end
    end

    // per-sample result and saturating statistics; clear overrides any same-cycle update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid  <= 1'b0;
            err_abs    <= '0;
            err_sum    <= '0;
            err_max    <= '0;
            sample_cnt <= '0;
            skip_cnt   <= '0;
        end else begin
            res_valid <= (state == ACC);
            if (state == ACC) err_abs <= err_new;
            if (clear) begin
                err_sum    <= '0;
                err_max    <= '0;
                sample_cnt <= '0;
                skip_cnt   <= '0;
            end else if (state == ACC) begin
                err_sum <= sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
                if (err_new > err_max) err_max <= err_new;
                if (sample_cnt != {CNT_W{1'b1}}) sample_cnt <= sample_cnt + CNT_W'(1);
            end else if ((state == CHECK) && skip_s) begin
                if (skip_cnt != {CNT_W{1'b1}}) skip_cnt <= skip_cnt + CNT_W'(1);
            end
        end
    end

`ifdef DIV_MAE_REM_CHECK_EN
    logic [DW-1:0] r_apx_r;
    logic          unused_seq;
    assign unused_seq = seq_busy;

    // remainder reported by the approximate divider vs. exact final remainder
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_apx_r     <= '0;
            rem_mis_cnt <= '0;
        end else begin
            if (in_valid && in_ready) r_apx_r <= r_apx;
            if (clear) begin
                rem_mis_cnt <= '0;
            end else if ((state == ACC) && (r_apx_r != seq_rem)) begin
                if (rem_mis_cnt != {CNT_W{1'b1}}) rem_mis_cnt <= rem_mis_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_rem;
    assign unused_rem  = ^{r_apx, seq_rem, seq_busy};
    assign rem_mis_cnt = '0;
`endif

endmodule

// File: tb/tb_div_mae_monitor.sv
// Scoreboard bench for div_mae_monitor: default instance plus an ACC_W=8 instance for saturation.
module tb_div_mae_monitor;

    logic        clk = 1'b0;
    logic        rst, in_valid, clear;
    logic [15:0] n;
    logic [7:0]  d, q_apx, r_apx;

    logic        in_ready, res_valid;
    logic [7:0]  err_abs, err_max;
    logic [31:0] err_sum;
    logic [23:0] sample_cnt, skip_cnt, rem_mis_cnt;

    logic        in_ready8, res_valid8;
    logic [7:0]  err_abs8, err_max8, err_sum8;
    logic [23:0] sample_cnt8, skip_cnt8, rem_mis_cnt8;

    typedef struct {
        bit          skip;
        logic [7:0]  err;
        logic [31:0] sum;
        logic [7:0]  sum8;
        logic [7:0]  emax;
        logic [23:0] scnt;
        logic [23:0] kcnt;
        logic [23:0] rcnt;
    } exp_t;

    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    longint m_sum, m_sum8;
    int     m_max, m_scnt, m_kcnt, m_rcnt;

    always #5 clk = ~clk;

    div_mae_monitor dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .n(n), .d(d), .q_apx(q_apx), .r_apx(r_apx), .clear(clear),
        .res_valid(res_valid), .err_abs(err_abs), .err_sum(err_sum), .err_max(err_max),
        .sample_cnt(sample_cnt), .skip_cnt(skip_cnt), .rem_mis_cnt(rem_mis_cnt)
    );

    div_mae_monitor #(.ACC_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .n(n), .d(d), .q_apx(q_apx), .r_apx(r_apx), .clear(clear),
        .res_valid(res_valid8), .err_abs(err_abs8), .err_sum(err_sum8), .err_max(err_max8),
        .sample_cnt(sample_cnt8), .skip_cnt(skip_cnt8), .rem_mis_cnt(rem_mis_cnt8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_zero();
        m_sum = 0; m_sum8 = 0; m_max = 0; m_scnt = 0; m_kcnt = 0; m_rcnt = 0;
    endtask

    task automatic drive(input logic [15:0] nn, input logic [7:0] dd, input logic [7:0] qa,
                         input logic [7:0] ra);
        @(negedge clk);
        check("in_ready_before_send", in_ready, 1'b1);
        n = nn; d = dd; q_apx = qa; r_apx = ra; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send(input logic [15:0] nn, input logic [7:0] dd, input logic [7:0] qa,
                        input logic [7:0] ra, input bit clr_acc);
        exp_t e;
        int   lat;
        int   q, r, err;
        e.skip = (dd == 8'd0);
        if (!e.skip) e.skip = ((int'(nn) / int'(dd)) > 255);
        err = 0;
        if (e.skip) begin
            m_kcnt++;
        end else begin
            q   = int'(nn) / int'(dd);
            r   = int'(nn) % int'(dd);
            err = (int'(qa) > q) ? int'(qa) - q : q - int'(qa);
            if (clr_acc) begin
                model_zero();
            end else begin
                m_sum  = (m_sum + err > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sum + err;
                m_sum8 = (m_sum8 + err > 255) ? 255 : m_sum8 + err;
                if (err > m_max) m_max = err;
                m_scnt++;
`ifdef DIV_MAE_REM_CHECK_EN
                if (int'(ra) != r) m_rcnt++;
`endif
            end
        end
        e.err = err[7:0]; e.sum = m_sum[31:0]; e.sum8 = m_sum8[7:0]; e.emax = m_max[7:0];
        e.scnt = m_scnt[23:0]; e.kcnt = m_kcnt[23:0]; e.rcnt = m_rcnt[23:0];
        sb.push_back(e);

        drive(nn, dd, qa, ra);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (clr_acc && k == 9) clear = 1'b1;
            if (res_valid) begin
                lat = k;
                break;
            end
        end
        e = sb.pop_front();
        if (e.skip) begin
            check("skip_no_res_valid", lat, 0);
        end else begin
            check("res_latency", lat, 10);
            check("err_abs", err_abs, e.err);
            check("in_ready_at_result", in_ready, 1'b1);
        end
        clear = 1'b0;
        check("err_sum", err_sum, e.sum);
        check("err_sum_acc8", err_sum8, e.sum8);
        check("err_max", err_max, e.emax);
        check("sample_cnt", sample_cnt, e.scnt);
        check("skip_cnt", skip_cnt, e.kcnt);
        check("rem_mis_cnt", rem_mis_cnt, e.rcnt);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; clear = 1'b0;
        n = '0; d = '0; q_apx = '0; r_apx = '0;
        model_zero();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_err_sum", err_sum, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        @(negedge clk) rst = 1'b0;

        send(16'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        send(16'd100, 8'd7, 8'd12, 8'd2, 1'b0);
        send(16'd100, 8'd7, 8'd17, 8'd2, 1'b0);
        send(16'd100, 8'd0, 8'd0, 8'd0, 1'b0);
        send(16'h0800, 8'd4, 8'd0, 8'd0, 1'b0);
        send(16'd100, 8'd7, 8'd14, 8'd3, 1'b0);
        send(16'd100, 8'd7, 8'd214, 8'd2, 1'b0);
        send(16'd100, 8'd7, 8'd214, 8'd2, 1'b0);
        send(16'h06FF, 8'd7, 8'd0, 8'd6, 1'b0);
        send(16'h0700, 8'd7, 8'd0, 8'd0, 1'b0);
        send(16'd100, 8'd7, 8'd10, 8'd2, 1'b1);
        send(16'd200, 8'd3, 8'd66, 8'd2, 1'b0);

        // abort a sample in the middle of the restoring sequence
        drive(16'd100, 8'd7, 8'd14, 8'd2);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midcalc_in_ready", in_ready, 1'b1);
        check("midcalc_res_valid", res_valid, 1'b0);
        check("midcalc_err_abs", err_abs, 0);
        check("midcalc_err_sum", err_sum, 0);
        check("midcalc_err_max", err_max, 0);
        check("midcalc_sample_cnt", sample_cnt, 0);
        check("midcalc_skip_cnt", skip_cnt, 0);
        check("midcalc_rem_mis_cnt", rem_mis_cnt, 0);
        @(negedge clk) rst = 1'b0;
        model_zero();
        send(16'd255, 8'd5, 8'd51, 8'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
